reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the RISC core. Successor to the fixed 32x32, 2-read/1-write file.
- Adds configurable width, depth and port counts; hardwired zero register; true async reset of the array; a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (reads, issue) and writeback (writes, busy clear).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, >=2); AW = log2(NREGS).
- NRD, 2, number of read ports (1..4).
- NWR, 1, number of write ports (1..2).
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and issues.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  busy flag of the register addressed by each read port.
- wr_en  in  NWR  write enable per write port.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  issue: mark iss_addr busy (destination allocated in decode).
- iss_addr  in  AW  destination register being allocated.
- busy_vec  out  NREGS  full scoreboard, bit r = register r pending.

Behaviour:
- Reset (rst=0, asynchronous): all NREGS registers clear to 0; all busy bits clear to 0.
  - Outputs while in reset: rd_data=0, rd_busy=0, busy_vec=0.
  - Reset asserted mid-write: the write is lost. Release is synchronous to the next clk edge.
- Write: on posedge clk with wr_en[j]=1, Register[wr_addr[j]] <= wr_data[j].
  - Both ports writing the same address in one cycle: the higher port index (j=1) wins.
- Write also clears busy bit wr_addr[j] on the same edge.
- Issue: on posedge clk with iss_en=1, busy[iss_addr] <= 1.
  - Issue and write to the same address in one cycle: set wins, so busy stays 1 because a newer producer now exists.
- ZERO_REG=1:
  - reads of address 0 return 0 and rd_busy=0;
  - writes to 0 are discarded;
  - iss_en to 0 is ignored; busy_vec[0] is constantly 0.
- Read: combinational, zero-cycle latency.
  - rd_data[i] = Register[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
- Addresses >= NREGS cannot occur (NREGS is a power of 2).
- No handshake: the caller guarantees ordering. The scoreboard is advisory; stall decisions belong to the hazard unit.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-first forwarding. If wr_en[j]=1 and wr_addr[j]==rd_addr[i] (and the address is not a discarded reg-0 write), then:
  - rd_data[i] = wr_data[j] in the same cycle (highest j on conflict);
  - rd_busy[i] = 0, unless iss_en targets the same address.
- Undefined: reads return the pre-edge array contents; rd_busy reflects the registered busy state only.

Decomposition:
- Package rf_pkg:
  - function clog2 for AW;
  - localparam defaults (RF_XLEN=32, RF_NREGS=32);
  - typedef rf_addr_t (logic [AW-1:0]) for default sizing;
  - localparam RF_ZERO_ADDR = 0.
- Sub-module rf_scoreboard (NREGS, NWR, ZERO_REG): owns the busy flops with set/clear priority, async reset, outputs busy_vec.
- Read muxes and the array stay in reg_file_mp.

Test Plan:
- Reset then read: rst=0 for 3 cycles, release; read addrs 5 and 6 -> rd_data=0, rd_busy=0, busy_vec=0.
- Write/read: write 0xDEADBEEF to r7 at cycle N -> read r7 at N+1 returns 0xDEADBEEF.
  - With RF_BYPASS_EN, reading r7 during cycle N also returns 0xDEADBEEF.
  - Without it, reading r7 during cycle N returns the old value 0.
- Zero register: write 0x12345678 to r0 and iss_en to r0 -> reading r0 returns 0; busy_vec[0]=0.
- Dual-write conflict (NWR=2): port0 writes r3=0x1, port1 writes r3=0x2 same edge -> r3 reads 0x2.
- Scoreboard: iss r9 at N -> busy_vec[9]=1 at N+1. Write r9 at N+2 -> busy_vec[9]=0 at N+3. Issue and write r9 same edge -> busy_vec[9] stays 1.
- Async reset mid-operation: write r4=0xA5A5A5A5, then pulse rst low between clock edges -> rd_data for r4 goes 0 immediately, busy_vec=0, with no clock edge needed.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared sizing helpers and defaults for the multi-port register file.
package rf_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   localparam int unsigned RF_XLEN      = 32;
   localparam int unsigned RF_NREGS     = 32;
   localparam int unsigned RF_AW        = clog2(RF_NREGS);
   localparam int unsigned RF_ZERO_ADDR = 0;

   typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports, issue and scoreboard.
interface reg_file_mp_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NRD   = 2,
   parameter int unsigned NWR   = 1
);
   localparam int unsigned AW = rf_pkg::clog2(NREGS);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic [NREGS-1:0]    busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: writeback clears, issue sets, and a same-edge set beats the clear.
module rf_scoreboard import rf_pkg::*; #(
   parameter int unsigned NREGS    = RF_NREGS,
   parameter int unsigned NWR      = 1,
   parameter bit          ZERO_REG = 1'b1,
   localparam int unsigned AW      = clog2(NREGS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NWR-1:0]    wr_en_i,
   input  logic [NWR*AW-1:0] wr_addr_i,
   input  logic              iss_en_i,
   input  logic [AW-1:0]     iss_addr_i,
   output logic [NREGS-1:0]  busy_o
);

   logic [NREGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int unsigned j = 0; j < NWR; j++) begin
         if (wr_en_i[j]) busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
      // A new producer was allocated this cycle, so the older result no longer retires it.
      if (iss_en_i) busy_d[iss_addr_i] = 1'b1;
      if (ZERO_REG) busy_d[RF_ZERO_ADDR] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_mp import rf_pkg::*; #(
   parameter int unsigned XLEN     = RF_XLEN,
   parameter int unsigned NREGS    = RF_NREGS,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 1,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   reg_file_mp_if.slave  bus
);

   localparam int unsigned AW = clog2(NREGS);

   logic [XLEN-1:0]     mem_q [NREGS];
   logic [NREGS-1:0]    busy_vec;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [AW-1:0]       raddr;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return ZERO_REG && (a == AW'(RF_ZERO_ADDR));
   endfunction

   rf_scoreboard #(
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wr_en_i    (bus.wr_en),
      .wr_addr_i  (bus.wr_addr),
      .iss_en_i   (bus.iss_en),
      .iss_addr_i (bus.iss_addr),
      .busy_o     (busy_vec)
   );

   // Later write ports are applied last, so the highest index wins an address conflict.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= '0;
      end else begin
         for (int unsigned j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && !is_zero(bus.wr_addr[j*AW +: AW])) begin
               mem_q[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      raddr   = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         raddr                   = bus.rd_addr[i*AW +: AW];
         rd_data[i*XLEN +: XLEN] = mem_q[raddr];
         rd_busy[i]              = busy_vec[raddr];
`ifdef RF_BYPASS_EN
         // Gated by reset so the ports still read zero while the array is held clear.
         for (int unsigned j = 0; j < NWR; j++) begin
            if (rst_ni && bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == raddr) && !is_zero(raddr)) begin
               rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
               rd_busy[i]              = bus.iss_en && (bus.iss_addr == raddr);
            end
         end
`endif
         if (is_zero(raddr)) begin
            rd_data[i*XLEN +: XLEN] = '0;
            rd_busy[i]              = 1'b0;
         end
      end
   end

   assign bus.rd_data  = rd_data;
   assign bus.rd_busy  = rd_busy;
   assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_reg_file_mp;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NRD   = 2;
   localparam int unsigned NWR   = 2;
   localparam int unsigned AW    = 5;

   localparam int KData = 0;
   localparam int KBusy = 1;
   localparam int KVec  = 2;

`ifdef RF_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   typedef struct {
      string       name;
      int          kind;
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] mon_act;
   int          n_tests = 0;
   int          n_fail  = 0;

   logic clk = 1'b0;
   logic rst_ni;

   always #5 clk = ~clk;

   reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

   reg_file_mp #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NRD      (NRD),
      .NWR      (NWR),
      .ZERO_REG (1'b1)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   task automatic expect_item(input string name, input int kind, input int port,
                              input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.port = port;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en  = '0;
      bus.iss_en = 1'b0;
   endtask

   task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
      bus.wr_en[j]                = 1'b1;
      bus.wr_addr[j*AW +: AW]     = a;
      bus.wr_data[j*XLEN +: XLEN] = d;
   endtask

   task automatic rd(input int i, input logic [4:0] a);
      bus.rd_addr[i*AW +: AW] = a;
   endtask

   task automatic iss(input logic [4:0] a);
      bus.iss_en   = 1'b1;
      bus.iss_addr = a;
   endtask

   always @(negedge clk) begin
      while (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         case (mon_e.kind)
            KData:   mon_act = bus.rd_data[mon_e.port*XLEN +: XLEN];
            KBusy:   mon_act = 32'(bus.rd_busy[mon_e.port]);
            default: mon_act = bus.busy_vec;
         endcase
         n_tests++;
         if (mon_act !== mon_e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
         end
      end
   end

   initial begin
      rst_ni       = 1'b0;
      bus.rd_addr  = '0;
      bus.wr_en    = '0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.iss_en   = 1'b0;
      bus.iss_addr = '0;
      rd(0, 5'd5);
      rd(1, 5'd6);
      expect_item("in_reset_rd0",   KData, 0, 32'h0);
      expect_item("in_reset_rd1",   KData, 1, 32'h0);
      expect_item("in_reset_busy0", KBusy, 0, 32'h0);
      expect_item("in_reset_vec",   KVec,  0, 32'h0);
      repeat (3) cyc();
      rst_ni = 1'b1;
      cyc();
      expect_item("post_reset_rd0",   KData, 0, 32'h0);
      expect_item("post_reset_rd1",   KData, 1, 32'h0);
      expect_item("post_reset_busy1", KBusy, 1, 32'h0);
      expect_item("post_reset_vec",   KVec,  0, 32'h0);
      cyc();

      // r7 write, read during and after the write edge
      wr(0, 5'd7, 32'hDEADBEEF);
      rd(0, 5'd7);
      expect_item("r7_same_cycle", KData, 0, Byp ? 32'hDEADBEEF : 32'h0);
      expect_item("r7_busy_same",  KBusy, 0, 32'h0);
      cyc();
      idle();
      expect_item("r7_next_cycle", KData, 0, 32'hDEADBEEF);
      cyc();

      // zero register: write and issue both discarded
      wr(0, 5'd0, 32'h12345678);
      iss(5'd0);
      rd(0, 5'd0);
      expect_item("r0_same_rd",   KData, 0, 32'h0);
      expect_item("r0_same_busy", KBusy, 0, 32'h0);
      cyc();
      idle();
      expect_item("r0_rd",   KData, 0, 32'h0);
      expect_item("r0_busy", KBusy, 0, 32'h0);
      expect_item("r0_vec",  KVec,  0, 32'h0);
      cyc();

      // dual write to r3, port 1 wins
      wr(0, 5'd3, 32'h1);
      wr(1, 5'd3, 32'h2);
      rd(1, 5'd3);
      expect_item("r3_same_cycle", KData, 1, Byp ? 32'h2 : 32'h0);
      cyc();
      idle();
      expect_item("r3_dual_write", KData, 1, 32'h2);
      cyc();

      // scoreboard: issue, clear by write, set beats clear
      iss(5'd9);
      rd(0, 5'd9);
      expect_item("r9_iss_pre_vec",  KVec,  0, 32'h0);
      expect_item("r9_iss_pre_busy", KBusy, 0, 32'h0);
      cyc();
      idle();
      expect_item("r9_busy_vec", KVec,  0, 32'h0000_0200);
      expect_item("r9_rd_busy",  KBusy, 0, 32'h1);
      cyc();
      wr(0, 5'd9, 32'h99);
      expect_item("r9_wr_same_rd",   KData, 0, Byp ? 32'h99 : 32'h0);
      expect_item("r9_wr_same_busy", KBusy, 0, Byp ? 32'h0 : 32'h1);
      cyc();
      idle();
      expect_item("r9_cleared_vec",  KVec,  0, 32'h0);
      expect_item("r9_cleared_rd",   KData, 0, 32'h99);
      expect_item("r9_cleared_busy", KBusy, 0, 32'h0);
      cyc();
      wr(1, 5'd9, 32'hAB);
      iss(5'd9);
      expect_item("r9_setclr_same_rd",   KData, 0, Byp ? 32'hAB : 32'h99);
      expect_item("r9_setclr_same_busy", KBusy, 0, Byp ? 32'h1 : 32'h0);
      cyc();
      idle();
      expect_item("r9_setclr_vec",  KVec,  0, 32'h0000_0200);
      expect_item("r9_setclr_rd",   KData, 0, 32'hAB);
      expect_item("r9_setclr_busy", KBusy, 0, 32'h1);
      cyc();

      // async reset between clock edges
      wr(0, 5'd4, 32'hA5A5A5A5);
      rd(1, 5'd4);
      cyc();
      idle();
      expect_item("r4_written", KData, 1, 32'hA5A5A5A5);
      cyc();
      rst_ni = 1'b0;
      expect_item("async_rst_r4",    KData, 1, 32'h0);
      expect_item("async_rst_r9",    KData, 0, 32'h0);
      expect_item("async_rst_busy0", KBusy, 0, 32'h0);
      expect_item("async_rst_vec",   KVec,  0, 32'h0);
      cyc();
      rst_ni = 1'b1;
      rd(0, 5'd7);
      cyc();
      expect_item("after_rst_r4",  KData, 1, 32'h0);
      expect_item("after_rst_r7",  KData, 0, 32'h0);
      expect_item("after_rst_vec", KVec,  0, 32'h0);
      cyc();

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
